// File: rtl/fade_sequencer.sv
// rtl/fade_sequencer.sv - rate-controlled rise/hold/fall/hold address sequencer for the fade LUT ROM
module fade_sequencer #(
    parameter int STEP_DIV   = 195312,
    parameter int HOLD_TICKS = 64
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Pause,
    input  logic       Loop,
    input  logic [2:0] Step,
    output logic [7:0] Address,
    output logic [2:0] State,
    output logic       Busy,
    output logic       Done
);

    // Counter widths; the hold counter keeps at least one bit even when a
    // single hold tick is configured.
    localparam int PW = $clog2(STEP_DIV);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(STEP_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RISE    = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_FALL    = 3'd3,
        ST_HOLD_LO = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [7:0]    address, address_n;
    logic [PW-1:0] prescaler, prescaler_n;
    logic [HW-1:0] hold_cnt, hold_cnt_n;
    logic [3:0]    inc, inc_n;
    logic          done, done_n;

    // Helper values for the ramp arithmetic; the rise sum is 9 bits wide so
    // the saturation compare sees the carry instead of wrapping.
    logic          tick;
    logic [8:0]    rise_sum;
    logic [7:0]    fall_diff;
    logic [7:0]    inc_wide;
    logic [3:0]    step_inc;

    assign inc_wide  = {4'b0000, inc};
    assign rise_sum  = {1'b0, address} + {1'b0, inc_wide};
    assign fall_diff = address - inc_wide;
    assign step_inc  = {1'b0, Step} + 4'd1;

    // A step tick only happens while running and not paused.
    assign tick = (state != ST_IDLE) && !Pause && (prescaler == PRE_LAST);

    // State and datapath registers.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state     <= ST_IDLE;
            address   <= 8'd0;
            prescaler <= '0;
            hold_cnt  <= '0;
            inc       <= 4'd1;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            address   <= address_n;
            prescaler <= prescaler_n;
            hold_cnt  <= hold_cnt_n;
            inc       <= inc_n;
            done      <= done_n;
        end
    end

    // Next-state logic: Stop first, then Pause (outside IDLE), then the
    // tick-driven phase transitions.
    always_comb begin
        state_n     = state;
        address_n   = address;
        prescaler_n = prescaler;
        hold_cnt_n  = hold_cnt;
        inc_n       = inc;
        done_n      = 1'b0;

        if (Stop) begin
            state_n     = ST_IDLE;
            address_n   = 8'd0;
            prescaler_n = '0;
            hold_cnt_n  = '0;
        end else if (state == ST_IDLE) begin
            address_n   = 8'd0;
            prescaler_n = '0;
            hold_cnt_n  = '0;
            if (Start) begin
                state_n = ST_RISE;
                inc_n   = step_inc;
            end
        end else if (Pause) begin
            // Everything holds its value while paused.
            state_n = state;
        end else if (!tick) begin
            prescaler_n = prescaler + 1'b1;
        end else begin
            prescaler_n = '0;
            case (state)
                ST_RISE: begin
                    if (rise_sum >= 9'd255) begin
                        address_n  = 8'd255;
                        hold_cnt_n = '0;
                        state_n    = ST_HOLD_HI;
                    end else begin
                        address_n = rise_sum[7:0];
                    end
                end
                ST_HOLD_HI: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt_n = '0;
                        state_n    = ST_FALL;
                    end else begin
                        hold_cnt_n = hold_cnt + 1'b1;
                    end
                end
                ST_FALL: begin
                    if (address <= inc_wide) begin
                        address_n  = 8'd0;
                        hold_cnt_n = '0;
                        state_n    = ST_HOLD_LO;
                    end else begin
                        address_n = fall_diff;
                    end
                end
                ST_HOLD_LO: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt_n = '0;
                        if (Loop) begin
                            state_n = ST_RISE;
                            inc_n   = step_inc;
                        end else begin
                            state_n = ST_IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        hold_cnt_n = hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n   = ST_IDLE;
                    address_n = 8'd0;
                end
            endcase
        end
    end

    assign Address = address;
    assign State   = state;
    assign Busy    = (state != ST_IDLE);
    assign Done    = done;

endmodule

// File: tb/tb_fade_sequencer.sv
// tb/tb_fade_sequencer.sv - self-checking bench for fade_sequencer
module tb_fade_sequencer;

    localparam int SD = 4;
    localparam int HT = 2;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause, loop_en;
    logic [2:0] step;
    logic [7:0] Address;
    logic [2:0] State;
    logic       Busy, Done;

    always #5 clk = ~clk;

    fade_sequencer #(.STEP_DIV(SD), .HOLD_TICKS(HT)) dut (
        .CLOCK_50(clk),
        .Reset   (rst),
        .Start   (start),
        .Stop    (stop),
        .Pause   (pause),
        .Loop    (loop_en),
        .Step    (step),
        .Address (Address),
        .State   (State),
        .Busy    (Busy),
        .Done    (Done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase, address, active cycles into the current step
    // period, hold ticks remaining, increment and the done pulse.
    int m_state = 0, m_addr = 0, m_pre = 0, m_left = 0, m_inc = 1, m_done = 0;

    typedef struct {
        logic       r, st, sp, pa, lp;
        logic [2:0] stp;
        logic [7:0] a;
        logic [2:0] s;
        logic       b, d;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit st, input bit sp, input bit pa,
                              input bit lp, input int stp);
        int nxt;
        m_done = 0;
        if (r) begin
            m_state = 0; m_addr = 0; m_pre = 0; m_left = 0; m_inc = 1;
        end else if (sp) begin
            m_state = 0; m_addr = 0; m_pre = 0; m_left = 0;
        end else if (m_state == 0) begin
            if (st) begin
                m_state = 1;
                m_inc   = stp + 1;
                m_pre   = 0;
            end
        end else if (!pa) begin
            m_pre = m_pre + 1;
            if (m_pre == SD) begin
                m_pre = 0;
                case (m_state)
                    1: begin
                        nxt    = m_addr + m_inc;
                        m_addr = (nxt > 255) ? 255 : nxt;
                        if (m_addr == 255) begin m_state = 2; m_left = HT; end
                    end
                    2: begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_state = 3;
                    end
                    3: begin
                        nxt    = m_addr - m_inc;
                        m_addr = (nxt < 0) ? 0 : nxt;
                        if (m_addr == 0) begin m_state = 4; m_left = HT; end
                    end
                    4: begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            if (lp) begin m_state = 1; m_inc = stp + 1; end
                            else begin m_state = 0; m_done = 1; end
                        end
                    end
                    default: m_state = 0;
                endcase
            end
        end
    endtask

    // One clock: model follows the inputs seen at the edge, outputs compared 1 ns later.
    task automatic cyc();
        logic [31:0] expv;
        @(posedge clk);
        model_step(rst, start, stop, pause, loop_en, int'(step));
        #1;
        expv = {19'd0, m_addr[7:0], m_state[2:0], (m_state != 0), m_done[0]};
        check("model", {19'd0, Address, State, Busy, Done}, expv);
    endtask

    task automatic clear_inputs();
        rst = 0; start = 0; stop = 0; pause = 0; loop_en = 0; step = 3'd0;
    endtask

    initial begin
        int n;
        int seen_done;
        logic [7:0] prev;
        int seq[$];
        int expq[$];
        int act;

        clear_inputs();
        rst = 1;
        cyc();
        cyc();
        rst = 0;

        // {Reset,Start,Stop,Pause,Loop,Step, Address,State,Busy,Done}
        tbl[0]  = '{1, 0, 0, 0, 0, 3'd0,  8'd0, 3'd0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 3'd0,  8'd0, 3'd0, 0, 0};
        tbl[2]  = '{0, 1, 1, 0, 0, 3'd0,  8'd0, 3'd0, 0, 0};
        tbl[3]  = '{0, 1, 0, 0, 0, 3'd7,  8'd0, 3'd1, 1, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 3'd0,  8'd0, 3'd1, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 3'd0,  8'd0, 3'd1, 1, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 3'd0,  8'd0, 3'd1, 1, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 3'd0,  8'd8, 3'd1, 1, 0};
        tbl[8]  = '{0, 0, 0, 1, 0, 3'd0,  8'd8, 3'd1, 1, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 3'd0,  8'd8, 3'd1, 1, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 3'd0,  8'd8, 3'd1, 1, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 3'd0,  8'd8, 3'd1, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 3'd0, 8'd16, 3'd1, 1, 0};
        tbl[13] = '{0, 1, 0, 0, 0, 3'd2, 8'd16, 3'd1, 1, 0};
        tbl[14] = '{0, 0, 1, 0, 0, 3'd0,  8'd0, 3'd0, 0, 0};
        tbl[15] = '{0, 1, 0, 0, 0, 3'd0,  8'd0, 3'd1, 1, 0};
        tbl[16] = '{1, 0, 0, 0, 0, 3'd0,  8'd0, 3'd0, 0, 0};

        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].r; start = tbl[i].st; stop = tbl[i].sp;
            pause = tbl[i].pa; loop_en = tbl[i].lp; step = tbl[i].stp;
            cyc();
            check($sformatf("tbl%0d", i), {19'd0, Address, State, Busy, Done},
                  {19'd0, tbl[i].a, tbl[i].s, tbl[i].b, tbl[i].d});
        end
        clear_inputs();

        // Reset in the middle of a rise at Address=40.
        step = 3'd7; start = 1; cyc(); start = 0;
        n = 0;
        while (Address != 8'd40 && n < 400) begin cyc(); n++; end
        check("reach_40", {24'd0, Address}, 32'd40);
        rst = 1; cyc(); rst = 0;
        check("reset_mid_rise", {19'd0, Address, State, Busy, Done}, 32'd0);
        repeat (5) cyc();
        check("idle_after_reset", {29'd0, State}, 32'd0);

        // Full cycle, inc=1: Done exactly 2056 cycles after RISE entry.
        step = 3'd0; start = 1; cyc(); start = 0;
        n = 0;
        while (!Done && n < 3000) begin cyc(); n++; end
        check("done_latency", n, 32'd2056);
        cyc();
        check("done_single_pulse", {31'd0, Done}, 32'd0);

        // inc=8: exact list of addresses seen across one cycle.
        step = 3'd7; start = 1; cyc(); start = 0;
        prev = 8'd0; n = 0;
        while (!Done && n < 1000) begin
            cyc(); n++;
            if (Address != prev) begin seq.push_back(int'(Address)); prev = Address; end
        end
        for (int k = 1; k <= 31; k++) expq.push_back(8 * k);
        expq.push_back(255);
        for (int k = 1; k <= 31; k++) expq.push_back(255 - 8 * k);
        expq.push_back(0);
        check("seq_len", seq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            act = (i < seq.size()) ? seq[i] : 999;
            check($sformatf("seq_val%0d", i), act, expq[i]);
        end

        // Loop: return to RISE without Done; Step change in FALL used on the second rise.
        loop_en = 1; step = 3'd7; start = 1; cyc(); start = 0;
        seen_done = 0; n = 0;
        while (State != 3'd3 && n < 1000) begin cyc(); n++; seen_done |= Done; end
        step = 3'd3;
        while (State != 3'd4 && n < 2000) begin cyc(); n++; seen_done |= Done; end
        while (State == 3'd4 && n < 3000) begin cyc(); n++; seen_done |= Done; end
        check("loop_state", {29'd0, State}, 32'd1);
        check("loop_no_done", seen_done, 32'd0);
        n = 0;
        while (Address == 8'd0 && n < 100) begin cyc(); n++; end
        check("loop_new_inc", {24'd0, Address}, 32'd4);
        loop_en = 0; stop = 1; cyc(); stop = 0;

        // Pause 10 cycles in HOLD_HI delays FALL entry by 10; Start ignored.
        step = 3'd7; start = 1; cyc(); start = 0;
        n = 0;
        while (State != 3'd2 && n < 400) begin cyc(); n++; end
        check("reach_hold_hi", {29'd0, State}, 32'd2);
        n = 0;
        cyc(); cyc(); n = 2;
        pause = 1; start = 1;
        for (int i = 0; i < 10; i++) begin
            cyc(); n++;
            check("pause_addr", {24'd0, Address}, 32'd255);
        end
        pause = 0; start = 0;
        while (State != 3'd3 && n < 100) begin cyc(); n++; end
        check("pause_delay", n, 32'd18);
        stop = 1; cyc(); stop = 0;

        // Stop during FALL at Address=120 (inc=5), then Start+Stop in IDLE.
        step = 3'd4; start = 1; cyc(); start = 0;
        n = 0;
        while (!(State == 3'd3 && Address == 8'd120) && n < 2000) begin cyc(); n++; end
        check("reach_fall_120", {21'd0, State, Address}, {21'd0, 3'd3, 8'd120});
        stop = 1; cyc(); stop = 0;
        check("stop_in_fall", {19'd0, Address, State, Busy, Done}, 32'd0);
        seen_done = 0;
        repeat (4) begin cyc(); seen_done |= Done; end
        check("stop_no_done", seen_done, 32'd0);
        start = 1; stop = 1; cyc(); start = 0; stop = 0;
        check("start_stop_idle", {31'd0, Busy}, 32'd0);

        // Randomized stimulus against the model.
        for (int i = 0; i < 20000; i++) begin
            rst   = ($urandom % 3000) == 0;
            stop  = ($urandom % 400) == 0;
            pause = ($urandom % 6) == 0;
            start = ($urandom % 5) == 0;
            if (($urandom % 100) == 0) loop_en = $urandom % 2;
            step  = 3'($urandom);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
